// File: rtl/shift_out_tx.sv
// Serial frame transmitter: start bit 0, WIDTH data bits LSB first, stop bit 1,
// each bit held for CLKS_PER_BIT clocks. Valid/ready handshake on the payload.
module shift_out_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  output logic             sdo,
  output logic             busy,
  output logic             done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [IW-1:0]    idx, idx_nx;
  logic [WIDTH-1:0] sh, sh_nx;
  logic             sdo_nx, done_nx;
  logic             wrap;

  assign wrap  = (cnt == CW'(CLKS_PER_BIT - 1));
  assign ready = (state == IDLE);
  assign busy  = ~ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      sdo   <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      sh    <= sh_nx;
      sdo   <= sdo_nx;
      done  <= done_nx;
    end
  end

  // sdo is computed one edge ahead so the line is a flop with no output decode
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    sh_nx    = sh;
    sdo_nx   = sdo;
    done_nx  = 1'b0;
    if (state != IDLE)
      cnt_nx = wrap ? '0 : cnt + CW'(1);
    case (state)
      IDLE: begin
        sdo_nx = 1'b1;
        if (valid) begin
          state_nx = START;
          sh_nx    = data;
          sdo_nx   = 1'b0;
          cnt_nx   = '0;
        end
      end
      START: if (wrap) begin
        state_nx = DATA;
        idx_nx   = '0;
        sdo_nx   = sh[0];
        sh_nx    = sh >> 1;
      end
      DATA: if (wrap) begin
        if (idx == IW'(WIDTH - 1)) begin
          state_nx = STOP;
          sdo_nx   = 1'b1;
        end else begin
          idx_nx = idx + IW'(1);
          sdo_nx = sh[0];
          sh_nx  = sh >> 1;
        end
      end
      STOP: if (wrap) begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_out_tx.sv
// Scoreboard bench: two transmitters (4b/1clk and 8b/4clk) checked cycle by
// cycle against frames rebuilt from the accepted payloads.
module tb_shift_out_tx;

  localparam int N4 = (4 + 2) * 1;
  localparam int N8 = (8 + 2) * 4;

  typedef struct {
    logic [31:0] d;
    int          first;
  } fr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] data4;
  logic [7:0] data8;
  logic       valid4, valid8;
  logic       ready4, sdo4, busy4, done4;
  logic       ready8, sdo8, busy8, done8;

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  nf0 = 0;
  int  nf1 = 0;
  bit  fin = 1'b0;
  bit  fin_seen = 1'b0;
  fr_t q0[$];
  fr_t q1[$];

  logic [31:0] fd[2];
  int act[2] = '{0, 0};
  int k[2] = '{0, 0};
  int done_at[2] = '{-1, -1};

  shift_out_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) u4 (
    .clk(clk), .rst_n(rst_n), .data(data4), .valid(valid4),
    .ready(ready4), .sdo(sdo4), .busy(busy4), .done(done4)
  );

  shift_out_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) u8 (
    .clk(clk), .rst_n(rst_n), .data(data8), .valid(valid8),
    .ready(ready8), .sdo(sdo8), .busy(busy8), .done(done8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // line level at sample k of a frame: start 0, data LSB first, stop 1
  function automatic logic exp_bit(input logic [31:0] d, input int kk, input int w, input int c);
    int bi;
    bi = kk / c;
    if (bi == 0) return 1'b0;
    if (bi > w) return 1'b1;
    return d[bi-1];
  endfunction

  task automatic cmp(input string nm, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s t=%0t cyc=%0d got=%b want=%b", nm, $time, cyc, a, e);
    end
  endtask

  task automatic chk(input int ch, input logic s, input logic b, input logic r, input logic dn);
    int w, c, n;
    string p;
    fr_t f;
    w = ch ? 8 : 4;
    c = ch ? 4 : 1;
    n = (w + 2) * c;
    p = ch ? "w8" : "w4";
    if (act[ch] == 0) begin
      if (ch == 0 && q0.size() > 0 && q0[0].first == cyc) begin
        f = q0.pop_front(); fd[0] = f.d; act[0] = 1; k[0] = 0;
      end
      if (ch == 1 && q1.size() > 0 && q1[0].first == cyc) begin
        f = q1.pop_front(); fd[1] = f.d; act[1] = 1; k[1] = 0;
      end
    end
    if (act[ch] != 0) begin
      cmp({p, "_sdo"}, s, exp_bit(fd[ch], k[ch], w, c));
      cmp({p, "_busy"}, b, 1'b1);
      cmp({p, "_ready"}, r, 1'b0);
      cmp({p, "_done"}, dn, 1'b0);
      k[ch]++;
      if (k[ch] == n) begin
        act[ch] = 0;
        done_at[ch] = cyc + 1;
      end
    end else begin
      cmp({p, "_idle_sdo"}, s, 1'b1);
      cmp({p, "_idle_busy"}, b, 1'b0);
      cmp({p, "_idle_ready"}, r, 1'b1);
      cmp({p, "_idle_done"}, dn, logic'(cyc == done_at[ch]));
    end
  endtask

  // monitor: all comparisons live here
  initial begin
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        #1;
        cmp("rst_sdo4", sdo4, 1'b1);
        cmp("rst_ready4", ready4, 1'b1);
        cmp("rst_busy4", busy4, 1'b0);
        cmp("rst_done4", done4, 1'b0);
        cmp("rst_sdo8", sdo8, 1'b1);
        cmp("rst_ready8", ready8, 1'b1);
        cmp("rst_busy8", busy8, 1'b0);
        cmp("rst_done8", done8, 1'b0);
        q0.delete();
        q1.delete();
        act = '{0, 0};
        done_at = '{-1, -1};
      end else begin
        chk(0, sdo4, busy4, ready4, done4);
        chk(1, sdo8, busy8, ready8, done8);
        if (fin && !fin_seen) begin
          fin_seen = 1'b1;
          cmp("drain", logic'(q0.size() == 0 && q1.size() == 0 && act[0] == 0 && act[1] == 0), 1'b1);
        end
      end
    end
  end

  // drive one cycle; a payload counts as accepted when the model says the line is free
  task automatic tick(input logic v0, input logic [3:0] d0, input logic v1, input logic [7:0] d1);
    @(negedge clk);
    #1;
    valid4 = v0; data4 = d0;
    valid8 = v1; data8 = d1;
    if (v0 && cyc + 1 >= nf0) begin
      q0.push_back('{32'(d0), cyc + 1});
      nf0 = cyc + 1 + N4 + 1;
    end
    if (v1 && cyc + 1 >= nf1) begin
      q1.push_back('{32'(d1), cyc + 1});
      nf1 = cyc + 1 + N8 + 1;
    end
  endtask

  initial begin
    valid4 = 1'b0; data4 = '0;
    valid8 = 1'b0; data8 = '0;
    #3 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    nf0 = 0; nf1 = 0;

    tick(1'b1, 4'hA, 1'b0, 8'h00);
    repeat (9) tick(1'b0, 4'h0, 1'b0, 8'h00);

    repeat (20) tick(1'b1, 4'h3, 1'b0, 8'h00);
    repeat (3) tick(1'b0, 4'h0, 1'b0, 8'h00);

    tick(1'b1, 4'h5, 1'b0, 8'h00);
    repeat (9) tick(1'b0, 4'hF, 1'b0, 8'h00);

    tick(1'b1, 4'hC, 1'b0, 8'h00);
    tick(1'b0, 4'hC, 1'b0, 8'h00);
    tick(1'b0, 4'hC, 1'b0, 8'h00);
    @(posedge clk); #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    nf0 = 0; nf1 = 0;
    tick(1'b1, 4'h1, 1'b0, 8'h00);
    repeat (8) tick(1'b0, 4'h0, 1'b0, 8'h00);

    tick(1'b0, 4'h0, 1'b1, 8'h81);
    repeat (45) tick(1'b0, 4'h0, 1'b0, 8'h00);

    repeat (600)
      tick(logic'($urandom_range(0, 2) == 0), 4'($urandom),
           logic'($urandom_range(0, 4) == 0), 8'($urandom));
    repeat (50) tick(1'b0, 4'h0, 1'b0, 8'h00);

    fin = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_out_tx.md
SHIFT_OUT_TX -- requirements
Module: shift_out_tx

Interface
REQ-001 Parameter WIDTH, default 8: payload bits per frame, legal range 1..32.
REQ-002 Parameter CLKS_PER_BIT, default 4: clk cycles per serial bit, legal range 1..256.
REQ-003 Port clk  input  1  sole clock, rising-edge active.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port data  input  WIDTH  parallel payload, sampled only on acceptance.
REQ-006 Port valid  input  1  payload-offered strobe.
REQ-007 Port ready  output  1  transmitter can accept a payload this cycle.
REQ-008 Port sdo  output  1  serial data line, registered, idle level 1.
REQ-009 Port busy  output  1  frame in progress (states START, DATA, STOP).
REQ-010 Port done  output  1  one-cycle pulse at the end of the stop bit.

Function
REQ-011 Single-clock FSM with four states: IDLE, START, DATA, STOP.
REQ-012 Frame format: one start bit 0, then WIDTH data bits LSB first, then one stop bit 1.
REQ-013 Each serial bit holds sdo stable for exactly CLKS_PER_BIT cycles; full frame = (WIDTH+2)*CLKS_PER_BIT cycles.
REQ-014 ready = 1 only in IDLE; busy = NOT ready at all times.
REQ-015 Acceptance = valid AND ready at a rising edge; data is latched into an internal WIDTH-bit shift register on that edge and the FSM moves IDLE->START.
REQ-016 Latency: sdo goes 0 (start bit) on the same edge that accepts the payload.
REQ-017 valid while ready = 0 is ignored; no queueing, no error indication.
REQ-018 data changes after acceptance do not affect the frame in flight.
REQ-019 Bit-period counter counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary, and is 0 on entry to every state.
REQ-020 START->DATA after CLKS_PER_BIT cycles; DATA advances one bit per wrap via a bit index 0..WIDTH-1; DATA->STOP when index WIDTH-1 wraps; STOP->IDLE after CLKS_PER_BIT cycles.
REQ-021 done = 1 for exactly the single cycle immediately after STOP->IDLE, coincident with ready rising.
REQ-022 At least one IDLE cycle with sdo = 1 separates consecutive frames, even when valid is held at 1.
REQ-023 CLKS_PER_BIT = 1: every bit lasts exactly one cycle, with no skipped or repeated bit.
REQ-024 WIDTH = 1: exactly one data bit is sent between the start and stop bits.
REQ-025 In IDLE, sdo = 1 and the shift register holds its value.

Reset
REQ-026 rst_n = 0 forces, immediately and without waiting for clk: state IDLE, sdo = 1, ready = 1, busy = 0, done = 0, counters = 0, shift register = 0.
REQ-027 Reset asserted mid-frame aborts the frame; no done pulse; any partial frame is discarded.
REQ-028 After rst_n rises, the first rising edge with valid = 1 is accepted.

Verification (WIDTH=4, CLKS_PER_BIT=1 unless stated)
REQ-029 Reset: rst_n=0 with no clk edge -> sdo=1, ready=1, busy=0, done=0 within the same timestep.
REQ-030 Single frame: data=4'hA, valid pulsed one cycle -> sdo sequence 0,0,1,0,1,1 on successive cycles; done on cycle 7; ready=0 for cycles 1-6.
REQ-031 Held valid: data=4'h3, valid=1 continuously -> frame 0,1,1,0,0,1, one idle cycle at 1, then the next frame starts.
REQ-032 Data change: accept 4'h5, change data to 4'hF on the next cycle -> data bits sent are still 1,0,1,0.
REQ-033 Abort: assert rst_n=0 during the second data bit of 4'hC -> sdo=1 at once, no done, and a later frame of 4'h1 is sent correctly.
REQ-034 Timing: CLKS_PER_BIT=4, WIDTH=8, data=8'h81 -> each bit lasts 4 cycles, frame lasts 40 cycles, done asserted exactly once.
